// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter feeding a two-stage pipelined saturating signed adder.
// Results carry the issuing requester's ID and a clamp flag, in acceptance order.
module sat_add_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_sum,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic                          out_sat
);

    localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_MAX = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [ID_WIDTH-1:0]   rr_ptr_reg;
    logic                  s1_valid_reg;
    logic [DATA_WIDTH-1:0] s1_a_reg, s1_b_reg;
    logic [ID_WIDTH-1:0]   s1_id_reg;
    logic                  out_valid_reg, out_sat_reg;
    logic [DATA_WIDTH-1:0] out_sum_reg;
    logic [ID_WIDTH-1:0]   out_id_reg;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_any;
    logic                  s1_adv, s2_adv;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] sum_next;
    logic                  sat_next;

    assign s2_adv = !out_valid_reg || out_ready;
    assign s1_adv = !s1_valid_reg || s2_adv;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi]     = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = grant[gi] && s1_adv;
        end
    endgenerate

    // Search starts one past the last accepted requester; independent of out_ready.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_WIDTH'(idx);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sum_ext  = {s1_a_reg[DATA_WIDTH-1], s1_a_reg} + {s1_b_reg[DATA_WIDTH-1], s1_b_reg};
        sum_next = sum_ext[DATA_WIDTH-1:0];
        sat_next = 1'b0;
        case (sum_ext[DATA_WIDTH:DATA_WIDTH-1])
            2'b01: begin
                sum_next = POS_MAX;
                sat_next = 1'b1;
            end
            2'b10: begin
                sum_next = NEG_MAX;
                sat_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= ID_WIDTH'(NUM_REQ - 1);
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_id_reg    <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= grant_any;
            if (grant_any) begin
                rr_ptr_reg <= grant_idx;
                s1_a_reg   <= a_arr[grant_idx];
                s1_b_reg   <= b_arr[grant_idx];
                s1_id_reg  <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_id_reg    <= '0;
            out_sat_reg   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_sum_reg <= sum_next;
                out_id_reg  <= s1_id_reg;
                out_sat_reg <= sat_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_id    = out_id_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed checks of arbitration order, saturation, backpressure and reset
// for sat_add_arbiter; inputs change on the falling edge, checks follow #1.
module tb_sat_add_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [1:0]  out_id;
    logic        out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    sat_add_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .ID_WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] s16(input int v);
        logic [31:0] t;
        t = v;
        return {16'b0, t[15:0]};
    endfunction

    task automatic set_pair(input int i, input int a, input int b);
        logic [31:0] ta, tb;
        ta = a;
        tb = b;
        req_a[i*16 +: 16] = ta[15:0];
        req_b[i*16 +: 16] = tb[15:0];
    endtask

    // Issue one pair from requester i, then check the result two edges later.
    task automatic one_shot(input string tag, input int i, input int a, input int b,
                            input int exp_sum, input int exp_sat);
        @(negedge clk);
        req_valid = 4'b0001 << i;
        set_pair(i, a, b);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(out_sum), s16(exp_sum));
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
        chk({tag, "_id"}, 32'(out_id), 32'(i));
    endtask

    initial begin
        int sent, recv, c;
        logic got_ready;
        logic [1:0] rr_seq [8];
        rr_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: grant visible in the same cycle, result two edges later
        @(negedge clk);
        req_valid = 4'b0100;
        set_pair(2, 100, -30);
        #1;
        chk("t1_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), s16(70));
        chk("t1_id", 32'(out_id), 32'd2);
        chk("t1_sat", 32'(out_sat), 32'd0);

        // Saturation corners
        one_shot("sat_pos", 0, 32767, 1, 32767, 1);
        one_shot("sat_neg", 0, -32768, -1, -32768, 1);
        one_shot("no_sat", 0, -32768, 32767, -1, 0);

        // Round robin with all requesters valid; rr_ptr is 0 after the last test
        for (int i = 0; i < 4; i++) set_pair(i, i * 10, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << rr_seq[k]));
            if (k >= 2) begin
                chk($sformatf("rr_id_%0d", k), 32'(out_id), 32'(rr_seq[k-2]));
                chk($sformatf("rr_sum_%0d", k), 32'(out_sum), s16(rr_seq[k-2] * 10 + 1));
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Backpressure: 6 pairs from requester 2, output stalled for 5 cycles
        sent = 0;
        recv = 0;
        c = 0;
        while (recv < 6 && c < 40) begin
            @(negedge clk);
            out_ready = (c >= 5);
            req_valid = (sent < 6) ? 4'b0100 : 4'b0000;
            set_pair(2, 1000 * (sent + 1), sent);
            #1;
            if (c < 5) chk($sformatf("bp_ready_%0d", c), 32'(req_ready), (c < 2) ? 32'h4 : 32'h0);
            if (c >= 2 && c < 5) begin
                chk($sformatf("bp_hold_valid_%0d", c), 32'(out_valid), 32'd1);
                chk($sformatf("bp_hold_sum_%0d", c), 32'(out_sum), s16(1000));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_sum_%0d", recv), 32'(out_sum), s16(1000 * (recv + 1) + recv));
                chk($sformatf("bp_id_%0d", recv), 32'(out_id), 32'd2);
                recv++;
            end
            got_ready = req_ready[2];
            @(posedge clk);
            if (got_ready) sent++;
            c++;
        end
        chk("bp_all_received", 32'(recv), 32'd6);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(posedge clk);

        // Fairness under stall: fill both stages from requester 0 (rr_ptr=0)
        @(negedge clk);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        set_pair(0, 5, 5);
        @(posedge clk);
        @(posedge clk);
        set_pair(1, 111, 0);
        set_pair(3, 333, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b1010;
            #1;
            chk($sformatf("fair_stall_ready_%0d", k), 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("fair_first", 32'(req_ready), 32'h2);
        @(negedge clk);
        #1;
        chk("fair_second", 32'(req_ready), 32'h8);
        @(negedge clk);
        #1;
        chk("fair_third", 32'(req_ready), 32'h2);
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        req_valid = 4'b0100;
        set_pair(2, 7, 7);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_pair(i, 20 + i, 2);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_id", 32'(out_id), 32'd0);
        chk("post_rst_sum", 32'(out_sum), s16(22));
        @(negedge clk);
        #1;
        chk("post_rst_drain", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
